// File: rtl/pmem_line_responder_if.sv
// pmem_line_responder_if
//   Physical-memory line bus between a cache (master) and a backing-memory
//   responder (slave). One 256-bit line per transaction.
//   pmem_read / pmem_write : request strobes, held by the master until resp
//   pmem_address           : byte address of the line (low 5 bits ignored)
//   pmem_wdata             : write line data
//   pmem_rdata             : read line data, valid in the resp cycle of a read
//   pmem_resp              : one-cycle completion strobe
interface pmem_line_responder_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/pmem_line_responder.sv
// pmem_line_responder
//   Fixed-latency backing-memory model for the cache's pmem line interface.
//   A request is accepted in IDLE, waits in BUSY, and completes with a single
//   pmem_resp cycle in RESP, LATENCY cycles after acceptance.
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   bus      : pmem line bus, slave side
//   busy     : a transaction is outstanding (BUSY or RESP)
//   err_both : sticky; read and write were both high at an acceptance
// Parameters:
//   LINES    : number of stored 256-bit lines, power of two, >= 2
//   LATENCY  : acceptance-to-resp cycles, >= 1
module pmem_line_responder #(
  parameter int LINES   = 256,
  parameter int LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pmem_line_responder_if.slave  bus,
  output logic                  busy,
  output logic                  err_both
);

  localparam int IW = $clog2(LINES);
  // Counter holds LATENCY-2 at most; keep at least one bit for small latencies.
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic          is_write;
    logic [IW-1:0] idx;
    logic [255:0]  wdata;
  } req_t;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  req_t            req_q, req_d;
  logic [255:0]    rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [LINES-1:0] valid_q, valid_d;

  logic [255:0]    mem [LINES];
  logic            mem_we;
  logic            enter_resp;
  logic [IW-1:0]   req_idx;

  // Upper address bits alias onto the index range; offset bits are ignored.
  assign req_idx = bus.pmem_address[5 +: IW];

  logic unused_addr_bits;
  generate
    if (5 + IW < 32) begin : g_upper
      assign unused_addr_bits = ^{bus.pmem_address[31:5+IW], bus.pmem_address[4:0]};
    end else begin : g_noupper
      assign unused_addr_bits = ^bus.pmem_address[4:0];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    valid_d    = valid_q;
    enter_resp = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.pmem_read || bus.pmem_write) begin
          // Write wins a read/write collision; the collision is flagged.
          req_d.is_write = bus.pmem_write;
          req_d.idx      = req_idx;
          req_d.wdata    = bus.pmem_wdata;
          err_d          = err_q | (bus.pmem_read & bus.pmem_write);
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The commit/read happens on the edge entering RESP. req_d is used so the
    // LATENCY==1 path sees the values being captured on that same edge.
    if (enter_resp) begin
      if (req_d.is_write) begin
        mem_we              = ~rst;
        valid_d[req_d.idx]  = 1'b1;
      end else begin
        rdata_d = valid_q[req_d.idx] ? mem[req_d.idx] : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  // Line storage has no reset; stale contents are masked by valid_q.
  always_ff @(posedge clk) begin
    if (mem_we) mem[req_d.idx] <= req_d.wdata;
  end

  assign bus.pmem_rdata = rdata_q;
  assign bus.pmem_resp  = (state_q == RESP);
  assign busy           = (state_q != IDLE);
  assign err_both       = err_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
module tb_pmem_line_responder;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy4, err4, busy1, err1;

  always #5 clk = ~clk;

  pmem_line_responder_if bus4 ();
  pmem_line_responder_if bus1 ();

  pmem_line_responder #(.LINES(256), .LATENCY(LAT)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .busy(busy4), .err_both(err4)
  );

  pmem_line_responder #(.LINES(256), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .busy(busy1), .err_both(err1)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model for the LATENCY=4 instance
  logic [255:0] mdata [256];
  logic         mval  [256];
  logic [255:0] last_rd;
  logic         exp_err;
  logic [255:0] sb_q [$];

  logic [255:0] pat_a, pat_b, pat_c, pat_d, e;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mval[i] = 1'b0;
    last_rd = '0;
    exp_err = 1'b0;
  endtask

  // One transaction on the LATENCY=4 instance, started in the current cycle
  // (cycle 0). Ends at the negedge of cycle LAT+1 with the bus idle.
  task automatic txn4(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [255:0] wd, input string tag);
    int idx;
    idx = int'(addr[12:5]);
    bus4.pmem_read    = rd;
    bus4.pmem_write   = wr;
    bus4.pmem_address = addr;
    bus4.pmem_wdata   = wd;
    if (wr) begin
      mdata[idx] = wd;
      mval[idx]  = 1'b1;
      if (rd) exp_err = 1'b1;
      sb_q.push_back(last_rd);
    end else begin
      e = mval[idx] ? mdata[idx] : '0;
      sb_q.push_back(e);
      last_rd = e;
    end
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".resp"}, 256'(bus4.pmem_resp), 256'(k == LAT));
      chk({tag, ".busy"}, 256'(busy4), 256'(1));
      if (bus4.pmem_resp && sb_q.size() != 0)
        chk({tag, ".rdata"}, bus4.pmem_rdata, sb_q.pop_front());
      if (k == LAT) begin
        bus4.pmem_read  = 1'b0;
        bus4.pmem_write = 1'b0;
      end
    end
    while (sb_q.size() != 0) void'(sb_q.pop_front());
    chk({tag, ".err_both"}, 256'(err4), 256'(exp_err));
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".idle_resp"}, 256'(bus4.pmem_resp), 256'(0));
    chk({tag, ".idle_busy"}, 256'(busy4), 256'(0));
    chk({tag, ".hold_rdata"}, bus4.pmem_rdata, last_rd);
  endtask

  initial begin
    bus4.pmem_read = 0; bus4.pmem_write = 0; bus4.pmem_address = '0; bus4.pmem_wdata = '0;
    bus1.pmem_read = 0; bus1.pmem_write = 0; bus1.pmem_address = '0; bus1.pmem_wdata = '0;
    pat_a = {8{32'hA5A5_0F0F}};
    pat_b = {4{64'h0123_4567_89AB_CDEF}};
    pat_c = {8{32'h1357_9BDF}};
    pat_d = {8{32'hCAFE_F00D}};
    for (int i = 0; i < 256; i++) mdata[i] = '0;
    model_reset();

    // Reset values
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.resp",  256'(bus4.pmem_resp), 256'(0));
    chk("rst.rdata", bus4.pmem_rdata, 256'(0));
    chk("rst.busy",  256'(busy4), 256'(0));
    chk("rst.err",   256'(err4), 256'(0));
    rst = 1'b0;
    @(negedge clk);

    // Read of never-written line returns zero
    txn4(1'b1, 1'b0, 32'h0000_0100, '0, "rd_invalid");

    // Offset bits ignored
    txn4(1'b0, 1'b1, 32'h0000_0120, {8{32'hDEADBEEF}}, "wr_beef");
    txn4(1'b1, 1'b0, 32'h0000_013C, '0, "rd_beef");

    // Index aliasing: 0x2040 maps to the same line as 0x0040
    txn4(1'b0, 1'b1, 32'h0000_0040, pat_a, "wr_alias");
    txn4(1'b1, 1'b0, 32'h0000_2040, '0, "rd_alias");

    // Read/write collision acts as a write and sets the sticky flag
    txn4(1'b1, 1'b1, 32'h0000_0060, pat_b, "both");
    txn4(1'b1, 1'b0, 32'h0000_0060, '0, "rd_both");
    txn4(1'b0, 1'b1, 32'h0000_0080, pat_c, "wr_after_err");
    txn4(1'b1, 1'b0, 32'h0000_0080, '0, "rd_after_err");

    // Reset in cycle 2 of a write: outputs return to reset values at once
    bus4.pmem_write   = 1'b1;
    bus4.pmem_address = 32'h0000_0200;
    bus4.pmem_wdata   = pat_d;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst.resp",  256'(bus4.pmem_resp), 256'(0));
    chk("mid_rst.rdata", bus4.pmem_rdata, 256'(0));
    chk("mid_rst.busy",  256'(busy4), 256'(0));
    chk("mid_rst.err",   256'(err4), 256'(0));
    bus4.pmem_write = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    txn4(1'b1, 1'b0, 32'h0000_0200, '0, "rd_aborted");
    txn4(1'b1, 1'b0, 32'h0000_0120, '0, "rd_after_rst");

    // LATENCY=1: write, then a read held one cycle past resp
    bus1.pmem_write   = 1'b1;
    bus1.pmem_address = 32'h0000_0300;
    bus1.pmem_wdata   = pat_c;
    @(posedge clk); @(negedge clk);
    chk("l1_wr.resp",  256'(bus1.pmem_resp), 256'(1));
    chk("l1_wr.rdata", bus1.pmem_rdata, 256'(0));
    bus1.pmem_write = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("l1_wr.idle", 256'(bus1.pmem_resp), 256'(0));

    bus1.pmem_read    = 1'b1;
    bus1.pmem_address = 32'h0000_0300;
    sb_q.push_back(pat_c);
    sb_q.push_back(pat_c);
    @(posedge clk); @(negedge clk);               // cycle 1
    chk("l1_rd1.resp", 256'(bus1.pmem_resp), 256'(1));
    chk("l1_rd1.busy", 256'(busy1), 256'(1));
    if (bus1.pmem_resp) chk("l1_rd1.rdata", bus1.pmem_rdata, sb_q.pop_front());
    @(posedge clk); @(negedge clk);               // cycle 2, request still high
    chk("l1_gap.resp", 256'(bus1.pmem_resp), 256'(0));
    chk("l1_gap.busy", 256'(busy1), 256'(0));
    @(posedge clk); #1 bus1.pmem_read = 1'b0;    // accepted at end of cycle 2
    @(negedge clk);                               // cycle 3
    chk("l1_rd2.resp", 256'(bus1.pmem_resp), 256'(1));
    if (bus1.pmem_resp && sb_q.size() != 0) chk("l1_rd2.rdata", bus1.pmem_rdata, sb_q.pop_front());
    @(posedge clk); @(negedge clk);               // cycle 4
    chk("l1_end.resp", 256'(bus1.pmem_resp), 256'(0));
    chk("l1_end.busy", 256'(busy1), 256'(0));
    chk("l1_end.err",  256'(err1), 256'(0));
    chk("l1_sb_empty", 256'(sb_q.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pmem_line_responder.md
Name: pmem_line_responder

Overview:
- Memory-side responder for the cache's physical-memory interface.
- Accepts 256-bit line read and write requests from the cache controller/datapath and models backing memory with a fixed, configurable latency.
- Returns a single-cycle pmem_resp strobe for each request.
- Used as the memory model in cache-level and CPU-level benches, and as the attachment point for a future real memory controller.

Parameters:
- LINES, 256, number of 256-bit lines stored; must be a power of two; index width IW = log2(LINES).
- LATENCY, 4, cycles from request acceptance to pmem_resp; must be >= 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- pmem_read  input  1  line read request; held until pmem_resp is seen.
- pmem_write  input  1  line write request; held until pmem_resp is seen.
- pmem_address  input  32  line address; bits [4:0] are ignored.
- pmem_wdata  input  256  write line data.
- pmem_rdata  output  256  read line data; valid in the pmem_resp cycle of a read.
- pmem_resp  output  1  one-cycle completion strobe.
- busy  output  1  high while a transaction is outstanding (BUSY or RESP state).
- err_both  output  1  sticky flag: pmem_read and pmem_write were both high at acceptance.

Behaviour:
- Reset (async, while rst=1):
  - State = IDLE; pmem_resp=0, pmem_rdata=0, busy=0, err_both=0, counter=0.
  - All per-line valid bits cleared. Line data contents are not reset.
  - An outstanding transaction is discarded; a pending write is never committed.
- Index = pmem_address[5+IW-1:5]. Upper address bits alias (wrap) modulo LINES.
- Reads of a line whose valid bit is 0 return 256'h0.
- State IDLE:
  - If pmem_read|pmem_write on an edge, accept it.
  - Capture the op (write has priority if both are high; err_both is then set and stays set until reset), index, and wdata.
  - If LATENCY==1, go to RESP; otherwise load counter = LATENCY-2 and go to BUSY.
- State BUSY:
  - Request inputs are ignored; the captured values are used.
  - If counter==0, go to RESP; otherwise decrement.
- Entering RESP (same edge):
  - Write: store the captured wdata to the line and set its valid bit.
  - Read: register the line data (or 0 if invalid) into pmem_rdata.
- State RESP:
  - pmem_resp=1 for exactly one cycle, then go to IDLE.
- Timing:
  - The request is accepted at the edge ending cycle 0; pmem_resp is high during cycle LATENCY.
  - The earliest next acceptance is the edge ending cycle LATENCY+1. A request still high in cycle LATENCY+1 is treated as a new transaction; the requester must drop it after seeing pmem_resp.
- pmem_rdata holds its last value outside RESP. A write's RESP leaves pmem_rdata unchanged.
- A read issued immediately after a write to the same line returns the new data (the commit happens before the read's acceptance).
- busy=1 in BUSY and RESP, 0 in IDLE.
- Storage is implemented as a synchronous array; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then read 0x0000_0100 with LATENCY=4 -> pmem_resp high only in cycle 4; pmem_rdata=0; busy high in cycles 1-4.
- Write 0x0000_0120 with data {8{32'hDEADBEEF}}, drop the request after resp, then read 0x0000_013C -> pmem_rdata={8{32'hDEADBEEF}} (offset bits ignored).
- LINES=256: write line address 0x0000_0040 with pattern A, then read 0x0000_2040 -> returns A (index wraps).
- Both pmem_read and pmem_write high at acceptance, with data B -> acts as a write of B, err_both=1 and stays 1 through later clean transactions until rst.
- Assert rst in cycle 2 of a write to 0x0000_0200 -> outputs return to reset values immediately; a later read of 0x0000_0200 returns 0.
- LATENCY=1 with back-to-back reads, request held one extra cycle after resp -> resp in cycles 1 and 3; the second read is served as a new transaction; no resp in cycle 2.
